bioz_sine_seq: RTL and testbench

//  Synthesizable BioZ excitation sequencer clocked by clk_SigGen from the clock generator (clk_SigGen = 32 x fbioz).

---
 rtl/bioz_sine_seq.sv | 181 ++++++++++++++++++
 tb/tb_bioz_sine_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/bioz_sine_seq.sv
// BioZ excitation sequencer: 32-entry sine table stepped once per clk_SigGen,
// gain-scaled offset-binary DAC code, square I/Q references, and whole-period
// amplitude ramps so enable/amplitude changes never cause step transients.
module bioz_sine_seq #(
  parameter int RAMP_PERIODS = 1
) (
  input  logic       clk_SigGen,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] amp_sel,
  output logic [7:0] dac_code,
  output logic [4:0] phase_idx,
  output logic       ref_I,
  output logic       ref_Q,
  output logic       period_tick,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, RAMP_UP, RUN, RAMP_DOWN} state_t;

  localparam logic [7:0] CNT_LAST = 8'(RAMP_PERIODS - 1);

  // round(128 + 127*sin(2*pi*k/32))
  function automatic logic [7:0] sin_lut(input logic [4:0] k);
    case (k)
      5'd0:  sin_lut = 8'd128;  5'd1:  sin_lut = 8'd153;
      5'd2:  sin_lut = 8'd177;  5'd3:  sin_lut = 8'd199;
      5'd4:  sin_lut = 8'd218;  5'd5:  sin_lut = 8'd234;
      5'd6:  sin_lut = 8'd245;  5'd7:  sin_lut = 8'd253;
      5'd8:  sin_lut = 8'd255;  5'd9:  sin_lut = 8'd253;
      5'd10: sin_lut = 8'd245;  5'd11: sin_lut = 8'd234;
      5'd12: sin_lut = 8'd218;  5'd13: sin_lut = 8'd199;
      5'd14: sin_lut = 8'd177;  5'd15: sin_lut = 8'd153;
      5'd16: sin_lut = 8'd128;  5'd17: sin_lut = 8'd103;
      5'd18: sin_lut = 8'd79;   5'd19: sin_lut = 8'd57;
      5'd20: sin_lut = 8'd38;   5'd21: sin_lut = 8'd22;
      5'd22: sin_lut = 8'd11;   5'd23: sin_lut = 8'd3;
      5'd24: sin_lut = 8'd1;    5'd25: sin_lut = 8'd3;
      5'd26: sin_lut = 8'd11;   5'd27: sin_lut = 8'd22;
      5'd28: sin_lut = 8'd38;   5'd29: sin_lut = 8'd57;
      5'd30: sin_lut = 8'd79;   default: sin_lut = 8'd103;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [4:0]  phase_q, phase_d;
  logic [3:0]  gain_q, gain_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  dac_q, dac_d;
  logic        ref_i_q, ref_i_d, ref_q_q, ref_q_d;
  logic        tick_q, tick_d, busy_q, busy_d;

  logic        wrap, hit;
  logic [3:0]  tgt;
  logic signed [8:0]  off_s;
  logic signed [12:0] prod_s, res_s;
  logic        unused_res;

  assign wrap = (state_q != IDLE) && (phase_q == 5'd31);
  assign hit  = (cnt_q == CNT_LAST);
  // amp_sel is only consulted on wrap edges, so decoding it live is the sample
  assign tgt  = 4'd8 >> amp_sel;

  // next-state, gain stepping and ramp counter
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    cnt_d   = cnt_q;
    phase_d = phase_q + 5'd1;
    case (state_q)
      IDLE: begin
        phase_d = 5'd0;
        if (enable) begin
          state_d = RAMP_UP;
          gain_d  = 4'd0;
          cnt_d   = 8'd0;
        end
      end
      RAMP_UP: begin
        if (!enable) begin
          state_d = RAMP_DOWN;
          cnt_d   = 8'd0;
        end else if (wrap) begin
          if (gain_q >= tgt) begin
            // target was lowered under us: settle in RUN, which steps down
            state_d = RUN;
            cnt_d   = 8'd0;
          end else if (hit) begin
            gain_d = gain_q + 4'd1;
            cnt_d  = 8'd0;
            if (gain_q + 4'd1 == tgt) state_d = RUN;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = RAMP_DOWN;
          cnt_d   = 8'd0;
        end else if (wrap) begin
          if (gain_q == tgt) begin
            // park at the last count so a new target steps on the next wrap
            cnt_d = hit ? cnt_q : cnt_q + 8'd1;
          end else if (hit) begin
            gain_d = (gain_q > tgt) ? gain_q - 4'd1 : gain_q + 4'd1;
            cnt_d  = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: begin // RAMP_DOWN
        if (enable) begin
          state_d = RAMP_UP;
          cnt_d   = 8'd0;
        end else if (wrap) begin
          if (gain_q == 4'd0) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end else if (hit) begin
            gain_d = gain_q - 4'd1;
            cnt_d  = 8'd0;
            if (gain_q == 4'd1) state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
    endcase
    if (state_d == IDLE) phase_d = 5'd0;
  end

  // outputs are computed from the next phase/gain so they register together
  always_comb begin
    busy_d  = (state_d != IDLE);
    tick_d  = wrap && busy_d;
    ref_i_d = busy_d && !phase_d[4];
    ref_q_d = busy_d && (phase_d[4] ^ phase_d[3]);
    off_s   = $signed({1'b0, sin_lut(phase_d)}) - 9'sd128;
    prod_s  = 13'(off_s) * $signed({9'd0, gain_d});
    res_s   = 13'sd128 + (prod_s >>> 3);
    dac_d   = res_s[7:0];
  end

  // gain <= 8 keeps the result inside 1..255, upper bits are sign only
  assign unused_res = ^res_s[12:8];

  // state and output registers
  always_ff @(posedge clk_SigGen or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= 5'd0;
      gain_q  <= 4'd0;
      cnt_q   <= 8'd0;
      dac_q   <= 8'd128;
      ref_i_q <= 1'b0;
      ref_q_q <= 1'b0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      gain_q  <= gain_d;
      cnt_q   <= cnt_d;
      dac_q   <= dac_d;
      ref_i_q <= ref_i_d;
      ref_q_q <= ref_q_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
    end
  end

  assign dac_code    = dac_q;
  assign phase_idx   = phase_q;
  assign ref_I       = ref_i_q;
  assign ref_Q       = ref_q_q;
  assign period_tick = tick_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_bioz_sine_seq.sv
// Directed bench for bioz_sine_seq: instance A (RAMP_PERIODS=1) covers reset,
// ramp-up, amplitude change, ramp-down and re-enable; instance B
// (RAMP_PERIODS=4) covers the stretched ramp.
module tb_bioz_sine_seq;

  logic       clk_SigGen = 1'b0;
  logic       rst_n;
  logic       en_a, en_b;
  logic [1:0] amp_a, amp_b;
  logic [7:0] a_dac, b_dac;
  logic [4:0] a_ph, b_ph;
  logic       a_ri, a_rq, a_tick, a_busy;
  logic       b_ri, b_rq, b_tick, b_busy;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int e         = 0;

  // hand-computed dac at k=8 for gains 7..1 during ramp-down
  int down_exp [7] = '{239, 223, 207, 191, 175, 159, 143};

  always #5 clk_SigGen = ~clk_SigGen;

  bioz_sine_seq #(.RAMP_PERIODS(1)) dut_a (
    .clk_SigGen(clk_SigGen), .rst_n(rst_n), .enable(en_a), .amp_sel(amp_a),
    .dac_code(a_dac), .phase_idx(a_ph), .ref_I(a_ri), .ref_Q(a_rq),
    .period_tick(a_tick), .busy(a_busy));

  bioz_sine_seq #(.RAMP_PERIODS(4)) dut_b (
    .clk_SigGen(clk_SigGen), .rst_n(rst_n), .enable(en_b), .amp_sel(amp_b),
    .dac_code(b_dac), .phase_idx(b_ph), .ref_I(b_ri), .ref_Q(b_rq),
    .period_tick(b_tick), .busy(b_busy));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // one edge, sampled 1 time unit later; dac range checked on both instances
  task automatic step();
    @(posedge clk_SigGen);
    #1;
    e++;
    total_cnt++;
    assert (a_dac >= 8'd1 && b_dac >= 8'd1) pass_cnt++;
    else $error("FAIL range at edge %0d: a=%0d b=%0d required 1..255", e, a_dac, b_dac);
  endtask

  task automatic adv_to(input int t);
    while (e < t) step();
  endtask

  initial begin
    rst_n = 1'b0; en_a = 1'b1; en_b = 1'b0; amp_a = 2'd0; amp_b = 2'd0;
    repeat (3) @(posedge clk_SigGen);
    #1;
    // T1: reset held with enable high
    chk("rst_dac",   a_dac, 128);
    chk("rst_busy",  a_busy, 0);
    chk("rst_phase", a_ph, 0);
    chk("rst_refI",  a_ri, 0);
    chk("rst_refQ",  a_rq, 0);
    chk("rst_tick",  a_tick, 0);
    chk("rst_b_dac", b_dac, 128);
    rst_n = 1'b1;
    step(); e = 0;                         // E0: RAMP_UP
    chk("e0_busy",  a_busy, 1);
    chk("e0_phase", a_ph, 0);
    chk("e0_dac",   a_dac, 128);
    // T2: ramp-up
    adv_to(31);
    chk("e31_phase", a_ph, 31);
    chk("e31_dac",   a_dac, 128);
    chk("e31_tick",  a_tick, 0);
    adv_to(32);
    chk("e32_phase", a_ph, 0);
    chk("e32_tick",  a_tick, 1);
    adv_to(33);
    chk("e33_tick",  a_tick, 0);
    adv_to(40);
    chk("e40_dac_g1", a_dac, 143);
    adv_to(256);
    chk("e256_tick", a_tick, 1);
    adv_to(264);
    chk("e264_dac", a_dac, 255);
    chk("e264_refI", a_ri, 1);
    chk("e264_refQ", a_rq, 1);
    adv_to(280);
    chk("e280_dac", a_dac, 1);
    chk("e280_refI", a_ri, 0);
    chk("e280_refQ", a_rq, 0);
    // T3: amp_sel=1 -> gain 4 after four wraps
    amp_a = 2'd1;
    adv_to(385);
    chk("g4_k1_dac", a_dac, 140);
    chk("g4_k1_refI", a_ri, 1);
    chk("g4_k1_refQ", a_rq, 0);
    adv_to(392);
    chk("g4_k8_dac", a_dac, 191);
    chk("g4_k8_refQ", a_rq, 1);
    adv_to(400);
    chk("g4_k16_dac", a_dac, 128);
    chk("g4_k16_refI", a_ri, 0);
    chk("g4_k16_refQ", a_rq, 1);
    adv_to(408);
    chk("g4_k24_dac", a_dac, 64);
    chk("g4_k24_refQ", a_rq, 0);
    // back to full scale, then T4: disable and ramp down
    amp_a = 2'd0;
    adv_to(520);
    chk("g8_again_dac", a_dac, 255);
    en_a = 1'b0;
    for (int i = 0; i < 7; i++) begin
      adv_to(552 + 32 * i);
      chk($sformatf("down_g%0d_dac", 7 - i), a_dac, down_exp[i]);
    end
    adv_to(767);
    chk("e767_busy", a_busy, 1);
    chk("e767_phase", a_ph, 31);
    adv_to(768);
    chk("idle_busy", a_busy, 0);
    chk("idle_dac", a_dac, 128);
    chk("idle_phase", a_ph, 0);
    chk("idle_refI", a_ri, 0);
    adv_to(769);
    chk("idle_hold_busy", a_busy, 0);
    chk("idle_hold_phase", a_ph, 0);
    // T5: re-enable mid ramp-down
    en_a = 1'b1;
    step(); e = 0;                         // F0
    chk("f0_busy", a_busy, 1);
    chk("f0_phase", a_ph, 0);
    adv_to(256);
    en_a = 1'b0;
    adv_to(264);
    chk("f264_dac", a_dac, 255);
    adv_to(424);
    chk("f424_g3_dac", a_dac, 175);
    en_a = 1'b1;
    adv_to(456);
    chk("f456_g4_dac", a_dac, 191);
    adv_to(584);
    chk("f584_g8_dac", a_dac, 255);
    adv_to(616);
    chk("f616_g8_dac", a_dac, 255);
    // T6: RAMP_PERIODS=4 instance
    en_b = 1'b1;
    step(); e = 0;                         // G0
    chk("b_g0_busy", b_busy, 1);
    chk("b_g0_phase", b_ph, 0);
    adv_to(32);
    chk("b_g32_tick", b_tick, 1);
    adv_to(40);
    chk("b_g40_dac", b_dac, 128);
    adv_to(120);
    chk("b_g120_dac", b_dac, 128);
    adv_to(136);
    chk("b_g136_dac_g1", b_dac, 143);
    adv_to(264);
    chk("b_g264_dac_g2", b_dac, 159);
    adv_to(1016);
    chk("b_g1016_dac_g7", b_dac, 16);
    adv_to(1032);
    chk("b_g1032_dac_g8", b_dac, 255);
    adv_to(1064);
    chk("b_g1064_dac_g8", b_dac, 255);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
